// File: rtl/mmc1_gen_if.sv
// CPU/PPU side bus of the MMC1-style bank mapper: write port, live addresses
// and the mapped bank/enable outputs.
interface mmc1_gen_if #(
  parameter int PRG_W = 4,
  parameter int CHR_W = 5
);
  logic             wr;
  logic [1:0]       cpu_sel;
  logic             cpu_d0;
  logic             cpu_d7;
  logic             cpu_a14;
  logic             cpu_wram;
  logic [2:0]       ppu_a;
  logic [PRG_W-1:0] prg_a;
  logic [CHR_W-1:0] chr_a;
  logic             ciram_a10;
  logic             wram_ce_n;

  modport master (
    output wr, cpu_sel, cpu_d0, cpu_d7, cpu_a14, cpu_wram, ppu_a,
    input  prg_a, chr_a, ciram_a10, wram_ce_n
  );

  modport slave (
    input  wr, cpu_sel, cpu_d0, cpu_d7, cpu_a14, cpu_wram, ppu_a,
    output prg_a, chr_a, ciram_a10, wram_ce_n
  );
endinterface

// File: rtl/mmc1_gen.sv
// MMC1-style mapper: serial-loaded ctrl/chr0/chr1/prg registers and the
// combinational PRG/CHR bank, nametable and PRG-RAM enable decode.
module mmc1_gen #(
  parameter int SHIFT_W       = 5,
  parameter int PRG_W         = 4,
  parameter int CHR_W         = 5,
  parameter bit IGNORE_CONSEC = 1'b1
) (
  input logic       ck,
  input logic       res,
  mmc1_gen_if.slave bus
);

  if (SHIFT_W < PRG_W + 1 || SHIFT_W < CHR_W || SHIFT_W < 5) begin : g_bad_params
    $error("mmc1_gen: SHIFT_W must be >= PRG_W+1, >= CHR_W and >= 5");
  end

  localparam int CNT_W = $clog2(SHIFT_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SHIFT_W - 1);

  typedef enum logic [1:0] {
    SEL_CTRL = 2'd0,
    SEL_CHR0 = 2'd1,
    SEL_CHR1 = 2'd2,
    SEL_PRG  = 2'd3
  } sel_e;

  logic [SHIFT_W-1:0] shift, ctrl, chr0, chr1, prg;
  logic [SHIFT_W-1:0] shift_in;
  logic [CNT_W-1:0]   count;
  logic               wr_prev;
  logic               accept;

  assign accept   = bus.wr && (!IGNORE_CONSEC || !wr_prev);
  assign shift_in = {bus.cpu_d0, shift[SHIFT_W-1:1]};

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent behaviour.
  always_ff @(posedge ck) begin
    if (res) begin
      shift   <= '0;
      count   <= '0;
      wr_prev <= 1'b0;
      ctrl    <= SHIFT_W'(5'b01100);
      chr0    <= '0;
      chr1    <= '0;
      prg     <= '0;
    end else begin
      wr_prev <= bus.wr;
      if (accept) begin
        if (bus.cpu_d7) begin
          shift      <= '0;
          count      <= '0;
          ctrl[3:2]  <= 2'b11;
        end else if (count == LAST) begin
          // Only the fifth (final) write's select matters.
          case (sel_e'(bus.cpu_sel))
            SEL_CTRL: ctrl <= shift_in;
            SEL_CHR0: chr0 <= shift_in;
            SEL_CHR1: chr1 <= shift_in;
            default:  prg  <= shift_in;
          endcase
          shift <= '0;
          count <= '0;
        end else begin
          shift <= shift_in;
          count <= count + 1'b1;
        end
      end
    end
  end

  // NOTE: every output gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    bus.ciram_a10 = 1'b0;
    bus.prg_a     = prg[PRG_W-1:0];
    bus.chr_a     = chr0[CHR_W-1:0];
    bus.wram_ce_n = ~(bus.cpu_wram & ~prg[PRG_W]);

    case (ctrl[1:0])
      2'd0:    bus.ciram_a10 = 1'b0;
      2'd1:    bus.ciram_a10 = 1'b1;
      2'd2:    bus.ciram_a10 = bus.ppu_a[0];
      default: bus.ciram_a10 = bus.ppu_a[1];
    endcase

    // 32K mode swaps bit 0 for live A14; 16K modes fix one half.
    case (ctrl[3:2])
      2'd0, 2'd1: bus.prg_a[0] = bus.cpu_a14;
      2'd2:       bus.prg_a    = bus.cpu_a14 ? prg[PRG_W-1:0] : '0;
      default:    bus.prg_a    = bus.cpu_a14 ? '1 : prg[PRG_W-1:0];
    endcase

    if (!ctrl[4]) bus.chr_a[0] = bus.ppu_a[2];
    else if (bus.ppu_a[2]) bus.chr_a = chr1[CHR_W-1:0];
  end

  // Upper register bits are stored but intentionally have no effect.
  logic unused_bits;
  assign unused_bits = ^{ctrl, chr0, chr1, prg};

endmodule

// File: tb/tb_mmc1_gen.sv
// Self-checking bench for mmc1_gen: directed scenarios with fixed expectations
// and a randomized run against a bit-list reference model.
module tb_mmc1_gen;

  logic       ck = 1'b0;
  logic       res;
  logic       wr, d0, d7, a14, wram;
  logic [1:0] sel;
  logic [2:0] ppu;

  always #5 ck = ~ck;

  mmc1_gen_if                         if0 ();
  mmc1_gen_if                         if1 ();
  mmc1_gen_if #(.PRG_W(5), .CHR_W(6)) if2 ();

  assign {if0.wr, if0.cpu_sel, if0.cpu_d0, if0.cpu_d7, if0.cpu_a14, if0.cpu_wram, if0.ppu_a} =
         {wr, sel, d0, d7, a14, wram, ppu};
  assign {if1.wr, if1.cpu_sel, if1.cpu_d0, if1.cpu_d7, if1.cpu_a14, if1.cpu_wram, if1.ppu_a} =
         {wr, sel, d0, d7, a14, wram, ppu};
  assign {if2.wr, if2.cpu_sel, if2.cpu_d0, if2.cpu_d7, if2.cpu_a14, if2.cpu_wram, if2.ppu_a} =
         {wr, sel, d0, d7, a14, wram, ppu};

  mmc1_gen dut0 (.ck(ck), .res(res), .bus(if0));
  mmc1_gen #(.IGNORE_CONSEC(1'b0)) dut1 (.ck(ck), .res(res), .bus(if1));
  mmc1_gen #(.SHIFT_W(6), .PRG_W(5), .CHR_W(6)) dut2 (.ck(ck), .res(res), .bus(if2));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model for the two default-width instances (k=0 ignores
  // back-to-back writes, k=1 does not): received bits kept as a list.
  int m_ctrl[2], m_chr0[2], m_chr1[2], m_prg[2];
  int m_bits[2][5];
  int m_n[2];
  bit m_prev[2];

  function automatic void model_step();
    for (int k = 0; k < 2; k++) begin
      bit acc;
      if (res) begin
        m_ctrl[k] = 12; m_chr0[k] = 0; m_chr1[k] = 0; m_prg[k] = 0;
        m_n[k] = 0; m_prev[k] = 1'b0;
        continue;
      end
      acc = wr && (k == 1 || !m_prev[k]);
      m_prev[k] = wr;
      if (!acc) continue;
      if (d7) begin
        m_n[k] = 0;
        m_ctrl[k] = m_ctrl[k] | 12;
      end else begin
        m_bits[k][m_n[k]] = int'(d0);
        m_n[k]++;
        if (m_n[k] == 5) begin
          int v = 0;
          for (int i = 0; i < 5; i++) v += m_bits[k][i] << i;
          case (sel)
            2'd0: m_ctrl[k] = v;
            2'd1: m_chr0[k] = v;
            2'd2: m_chr1[k] = v;
            default: m_prg[k] = v;
          endcase
          m_n[k] = 0;
        end
      end
    end
  endfunction

  function automatic int exp_ciram(int k);
    case (m_ctrl[k] & 3)
      0: return 0;
      1: return 1;
      2: return int'(ppu[0]);
      default: return int'(ppu[1]);
    endcase
  endfunction

  function automatic int exp_prg(int k);
    int lo = m_prg[k] & 15;
    case ((m_ctrl[k] >> 2) & 3)
      0, 1: return (lo & 14) | int'(a14);
      2: return a14 ? lo : 0;
      default: return a14 ? 15 : lo;
    endcase
  endfunction

  function automatic int exp_chr(int k);
    if (((m_ctrl[k] >> 4) & 1) == 0) return (m_chr0[k] & 30) | int'(ppu[2]);
    return ppu[2] ? (m_chr1[k] & 31) : (m_chr0[k] & 31);
  endfunction

  function automatic int exp_wce(int k);
    return (wram && ((m_prg[k] >> 4) & 1) == 0) ? 0 : 1;
  endfunction

  task automatic tick();
    @(posedge ck);
    model_step();
    #1;
  endtask

  task automatic write1(input logic [1:0] s, input logic b, input logic clr);
    wr = 1'b1; sel = s; d0 = b; d7 = clr;
    tick();
    wr = 1'b0; d7 = 1'b0;
    tick();
  endtask

  task automatic write5(input logic [1:0] s, input logic [4:0] bits);
    for (int i = 0; i < 5; i++) write1(s, bits[i], 1'b0);
  endtask

  task automatic probe(input logic a, input logic w, input logic [2:0] p);
    a14 = a; wram = w; ppu = p;
    #1;
  endtask

  task automatic do_reset();
    res = 1'b1;
    tick();
    res = 1'b0;
  endtask

  initial begin
    res = 1'b1; wr = 1'b0; sel = 2'd0; d0 = 1'b0; d7 = 1'b0;
    a14 = 1'b0; wram = 1'b0; ppu = 3'd0;
    tick();
    tick();
    res = 1'b0;

    // Reset defaults
    probe(1'b1, 1'b1, 3'b001);
    check("rst_ciram", 32'(if0.ciram_a10), 0);
    check("rst_prg_a14h", 32'(if0.prg_a), 32'hF);
    check("rst_wce_wram1", 32'(if0.wram_ce_n), 0);
    probe(1'b0, 1'b0, 3'b100);
    check("rst_prg_a14l", 32'(if0.prg_a), 0);
    check("rst_chr_p2h", 32'(if0.chr_a), 1);
    check("rst_wce_wram0", 32'(if0.wram_ce_n), 1);
    probe(1'b0, 1'b0, 3'b000);
    check("rst_chr_p2l", 32'(if0.chr_a), 0);

    // Wide configuration: six ones to prg
    for (int i = 0; i < 5; i++) write1(2'd3, 1'b1, 1'b0);
    probe(1'b0, 1'b1, 3'b000);
    check("w6_no_commit_at5", 32'(if2.prg_a), 0);
    write1(2'd3, 1'b1, 1'b0);
    probe(1'b0, 1'b1, 3'b000);
    check("w6_prg_a14l", 32'(if2.prg_a), 32'h1F);
    check("w6_wce", 32'(if2.wram_ce_n), 1);
    probe(1'b1, 1'b1, 3'b000);
    check("w6_prg_a14h", 32'(if2.prg_a), 32'h1F);
    do_reset();

    // prg = 01110 loaded LSB first
    write5(2'd3, 5'b01110);
    probe(1'b0, 1'b1, 3'b000);
    check("prg_mode3_lo", 32'(if0.prg_a), 32'hE);
    check("prg_wce_low", 32'(if0.wram_ce_n), 0);
    probe(1'b1, 1'b1, 3'b000);
    check("prg_mode3_hi", 32'(if0.prg_a), 32'hF);

    // ctrl = 10010, chr0 = 03, chr1 = 15
    write5(2'd0, 5'b10010);
    write5(2'd1, 5'h03);
    write5(2'd2, 5'h15);
    probe(1'b0, 1'b0, 3'b000);
    check("chr4k_lo", 32'(if0.chr_a), 32'h03);
    check("ciram_v0", 32'(if0.ciram_a10), 0);
    probe(1'b1, 1'b0, 3'b101);
    check("chr4k_hi", 32'(if0.chr_a), 32'h15);
    check("ciram_v1", 32'(if0.ciram_a10), 1);
    write5(2'd3, 5'b00101);
    probe(1'b0, 1'b0, 3'b000);
    check("prg_mode0_lo", 32'(if0.prg_a), 4);
    probe(1'b1, 1'b0, 3'b000);
    check("prg_mode0_hi", 32'(if0.prg_a), 5);

    // Aborted sequence, then chr0 = 11010
    for (int i = 0; i < 3; i++) write1(2'd0, 1'b1, 1'b0);
    write1(2'd0, 1'b0, 1'b1);
    write5(2'd1, 5'b11010);
    probe(1'b0, 1'b0, 3'b000);
    check("abort_chr0", 32'(if0.chr_a), 32'h1A);
    check("abort_prg_mode3", 32'(if0.prg_a), 5);
    probe(1'b1, 1'b0, 3'b001);
    check("abort_prg_hi", 32'(if0.prg_a), 32'hF);
    check("abort_ciram", 32'(if0.ciram_a10), 1);

    // Reset coinciding with a committing write
    for (int i = 0; i < 4; i++) write1(2'd3, 1'b1, 1'b0);
    wr = 1'b1; sel = 2'd3; d0 = 1'b1; res = 1'b1;
    tick();
    res = 1'b0; wr = 1'b0;
    tick();
    probe(1'b1, 1'b1, 3'b001);
    check("rstw_ciram", 32'(if0.ciram_a10), 0);
    check("rstw_prg_hi", 32'(if0.prg_a), 32'hF);
    check("rstw_wce", 32'(if0.wram_ce_n), 0);
    probe(1'b0, 1'b0, 3'b100);
    check("rstw_prg_lo", 32'(if0.prg_a), 0);
    check("rstw_chr", 32'(if0.chr_a), 1);
    write5(2'd3, 5'b00001);
    probe(1'b0, 1'b0, 3'b000);
    check("rstw_fresh_prg", 32'(if0.prg_a), 1);

    // Back-to-back writes: ignored vs counted
    do_reset();
    wr = 1'b1; sel = 2'd3; d0 = 1'b1;
    tick();
    tick();
    wr = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) write1(2'd3, 1'b0, 1'b0);
    probe(1'b0, 1'b0, 3'b000);
    check("consec_ign_pending", 32'(if0.prg_a), 0);
    check("consec_cnt_commit", 32'(if1.prg_a), 3);
    write1(2'd3, 1'b0, 1'b0);
    probe(1'b0, 1'b0, 3'b000);
    check("consec_ign_commit", 32'(if0.prg_a), 1);
    check("consec_cnt_hold", 32'(if1.prg_a), 3);

    // Randomized run against the reference model
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      res  = ($urandom_range(0, 63) == 0);
      wr   = 1'($urandom_range(0, 1));
      sel  = 2'($urandom_range(0, 3));
      d0   = 1'($urandom_range(0, 1));
      d7   = ($urandom_range(0, 11) == 0);
      a14  = 1'($urandom_range(0, 1));
      wram = 1'($urandom_range(0, 1));
      ppu  = 3'($urandom_range(0, 7));
      tick();
      check("rnd0_ciram", 32'(if0.ciram_a10), 32'(exp_ciram(0)));
      check("rnd0_prg", 32'(if0.prg_a), 32'(exp_prg(0)));
      check("rnd0_chr", 32'(if0.chr_a), 32'(exp_chr(0)));
      check("rnd0_wce", 32'(if0.wram_ce_n), 32'(exp_wce(0)));
      check("rnd1_ciram", 32'(if1.ciram_a10), 32'(exp_ciram(1)));
      check("rnd1_prg", 32'(if1.prg_a), 32'(exp_prg(1)));
      check("rnd1_chr", 32'(if1.chr_a), 32'(exp_chr(1)));
      check("rnd1_wce", 32'(if1.wram_ce_n), 32'(exp_wce(1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mmc1_gen.md
MMC1_GEN -- requirements
Module: mmc1_gen

Interface
REQ-001 SHALL provide parameter SHIFT_W, default 5, serial load register width in bits.
REQ-002 SHALL provide parameter PRG_W, default 4, PRG bank output width (CPU A14 upward).
REQ-003 SHALL provide parameter CHR_W, default 5, CHR bank output width (PPU A12 upward).
REQ-004 SHALL provide parameter IGNORE_CONSEC, default 1; when 1, the second and later cycles of back-to-back writes are ignored.
REQ-005 SHALL reject, at elaboration, any setting where SHIFT_W < PRG_W+1 or SHIFT_W < CHR_W.
REQ-006 ck  input  1  clock; one rising edge per CPU cycle; one clock, sampled on the rising edge.
REQ-007 res  input  1  reset, synchronous and active-high.
REQ-008 wr  input  1  CPU write strobe to $8000-$FFFF, valid for one ck per CPU write cycle.
REQ-009 cpu_sel  input  2  CPU A14:A13 at write time; register select.
REQ-010 cpu_d0  input  1  serial data bit.
REQ-011 cpu_d7  input  1  shift-clear bit.
REQ-012 cpu_a14  input  1  current CPU A14, used for PRG mapping.
REQ-013 cpu_wram  input  1  high when the CPU address is $6000-$7FFF.
REQ-014 ppu_a  input  3  PPU A12:A10.
REQ-015 prg_a  output  PRG_W  PRG ROM A14 upward.
REQ-016 chr_a  output  CHR_W  CHR A12 upward.
REQ-017 ciram_a10  output  1  nametable RAM A10.
REQ-018 wram_ce_n  output  1  PRG-RAM chip enable, active-low.

Function
REQ-019 SHALL accept a write when wr=1 and either IGNORE_CONSEC=0 or wr was 0 on the previous edge; a one-bit wr_prev flop SHALL track wr every cycle.
REQ-020 SHALL, on an accepted write with cpu_d7=1, empty the shift register, set count to 0 and set ctrl[3:2]=2'b11; no other register SHALL change.
REQ-021 SHALL, on an accepted write with cpu_d7=0 and count<SHIFT_W-1, shift right with cpu_d0 entering the MSB and increment count.
REQ-022 SHALL, on an accepted write with cpu_d7=0 and count=SHIFT_W-1, commit {cpu_d0, shift[SHIFT_W-1:1]} to the register selected by cpu_sel on that write: 0=ctrl, 1=chr0, 2=chr1, 3=prg. It SHALL then clear shift and count.
REQ-023 SHALL clear count on commit, so count wraps from SHIFT_W-1 to 0.
REQ-024 SHALL ignore cpu_sel on every write except the committing write.
REQ-025 SHALL drive all outputs combinationally from registers and current addresses; a committed value SHALL be visible on outputs from the cycle after the committing edge.
REQ-026 SHALL drive ciram_a10 from ctrl[1:0]: 0 gives 0, 1 gives 1, 2 gives ppu_a[0] (vertical), 3 gives ppu_a[1] (horizontal).
REQ-027 SHALL map PRG from ctrl[3:2]: modes 0/1 drive {prg[PRG_W-1:1], cpu_a14}.
REQ-028 SHALL, in PRG mode 2, drive 0 when cpu_a14=0 and prg[PRG_W-1:0] otherwise.
REQ-029 SHALL, in PRG mode 3, drive prg[PRG_W-1:0] when cpu_a14=0 and all-ones otherwise.
REQ-030 SHALL, when ctrl[4]=0, drive chr_a={chr0[CHR_W-1:1], ppu_a[2]}.
REQ-031 SHALL, when ctrl[4]=1, drive chr_a=chr0[CHR_W-1:0] if ppu_a[2]=0 and chr1[CHR_W-1:0] otherwise.
REQ-032 SHALL drive wram_ce_n = ~(cpu_wram & ~prg[PRG_W]).
REQ-033 SHALL ignore ctrl bits above bit 4, chr bits above CHR_W-1 and prg bits above PRG_W; these bits SHALL be stored but have no effect.

Reset
REQ-034 SHALL, when res=1 at an edge, set shift=0, count=0, wr_prev=0, ctrl=5'b01100 (zero-extended to SHIFT_W), and chr0=chr1=prg=0.
REQ-035 SHALL give res priority over a simultaneous wr; a reset mid-sequence SHALL discard partial shift data.
REQ-036 SHALL, after reset with defaults, drive ciram_a10=0, prg_a=4'hF for cpu_a14=1 and 4'h0 for cpu_a14=0, chr_a={4'h0,ppu_a[2]}, and wram_ce_n=~cpu_wram.

Verification
REQ-037 Writing five d0 bits 0,1,1,1,0 (LSB first) to sel=3 on non-adjacent cycles -> prg=5'b01110, prg_a=4'hE when cpu_a14=0 in mode 3, and wram_ce_n stays low for cpu_wram=1.
REQ-038 Writing ctrl=5'b10010, then chr0=5'h03 and chr1=5'h15 -> chr_a=5'h03 for ppu_a[2]=0, chr_a=5'h15 for ppu_a[2]=1, and ciram_a10 follows ppu_a[0].
REQ-039 With IGNORE_CONSEC=1, holding wr high for 2 cycles with d0=1 -> count advances by 1 only; with IGNORE_CONSEC=0 -> count advances by 2.
REQ-040 Three serial writes followed by a d7=1 write, then five writes to sel=1 -> only the last five bits land in chr0, and ctrl[3:2]=2'b11.
REQ-041 res asserted on the same edge as a committing write -> no register changes and all reset values of REQ-034 hold.
REQ-042 SHIFT_W=6, PRG_W=5, CHR_W=6, with six writes of 1 to sel=3 -> prg_a=5'h1F and wram_ce_n=1 for cpu_wram=1.
